// File: rtl/mem_map_pkg.sv
// Address map, requester port identifiers and access-legality rule shared by
// the memory access arbiter and its address checkers.
package mem_map_pkg;

  localparam logic [11:0] REGION_IMEM  = 12'h010;
  localparam logic [11:0] REGION_CONST = 12'h001;
  localparam logic [11:0] REGION_DMEM  = 12'h800;

  typedef enum logic {
    PORT_FETCH,
    PORT_DATA
  } port_e;

  // Fetches come only from instruction space; loads may also read constants;
  // stores may only touch data space. All accesses must be word aligned.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic        is_fetch,
                                      input logic        is_store);
    logic        aligned;
    logic [11:0] region;
    aligned = (addr[1:0] == 2'b00);
    region  = addr[31:20];
    if (is_fetch)
      addr_legal = aligned && (region == REGION_IMEM);
    else if (is_store)
      addr_legal = aligned && (region == REGION_DMEM);
    else
      addr_legal = aligned && ((region == REGION_CONST) || (region == REGION_DMEM));
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_access_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rdy;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rdy;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_rw;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_pca;
  logic [31:0] mem_wdata;
  logic [31:0] mem_out;
  logic [31:0] mem_iout;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out, mem_iout,
    output if_rdy, if_rvalid, if_rdata, if_err,
    output d_rdy, d_rvalid, d_rdata, d_err,
    output mem_rw, mem_wr, mem_addr, mem_pca, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out, mem_iout,
    input  if_rdy, if_rvalid, if_rdata, if_err,
    input  d_rdy, d_rvalid, d_rdata, d_err,
    input  mem_rw, mem_wr, mem_addr, mem_pca, mem_wdata
  );

endinterface

// File: rtl/mem_access_arbiter_addr_check.sv
// Combinational legality decode for one requester port.
// Checks are active only when MEM_ARB_ERR_CHECK_EN is defined; otherwise err is 0.
module mem_addr_check
  import mem_map_pkg::*;
(
  input  logic [31:0] addr,
  input  logic        is_fetch,
  input  logic        is_store,
  output logic        err
);

`ifdef MEM_ARB_ERR_CHECK_EN
  assign err = !addr_legal(addr, is_fetch, is_store);
`else
  logic unused_chk;
  assign unused_chk = ^{addr, is_fetch, is_store};
  assign err        = 1'b0;
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Serialises fetch and load/store traffic onto one memory access per cycle,
// data first with a starvation guard. Error checks gated by MEM_ARB_ERR_CHECK_EN.
module mem_access_arbiter
  import mem_map_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starve;
  logic       f_acc;
  logic       d_acc;
  logic       f_chk_err;
  logic       d_chk_err;

  logic       iss_valid;
  port_e      iss_port;
  logic       iss_we;
  logic       iss_err;

  // Ready signals are forced low during reset so every output reads 0.
  assign starve     = (starve_cnt == LIMIT) && bus.if_req;
  assign bus.d_rdy  = !rst && !starve;
  assign bus.if_rdy = !rst && (starve || !bus.d_req);
  assign d_acc      = bus.d_req && bus.d_rdy;
  assign f_acc      = bus.if_req && bus.if_rdy;

  mem_addr_check u_if_check (
    .addr     (bus.if_addr),
    .is_fetch (1'b1),
    .is_store (1'b0),
    .err      (f_chk_err)
  );

  mem_addr_check u_d_check (
    .addr     (bus.d_addr),
    .is_fetch (1'b0),
    .is_store (bus.d_we),
    .err      (d_chk_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (!bus.if_req || f_acc)
      starve_cnt <= '0;
    else if (d_acc && (starve_cnt != LIMIT))
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Issue stage; the memory address/data registers double as its payload and
  // simply hold while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid     <= 1'b0;
      iss_port      <= PORT_FETCH;
      iss_we        <= 1'b0;
      iss_err       <= 1'b0;
      bus.mem_pca   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (f_acc) begin
      iss_valid     <= 1'b1;
      iss_port      <= PORT_FETCH;
      iss_we        <= 1'b0;
      iss_err       <= f_chk_err;
      bus.mem_pca   <= bus.if_addr;
    end else if (d_acc) begin
      iss_valid     <= 1'b1;
      iss_port      <= PORT_DATA;
      iss_we        <= bus.d_we;
      iss_err       <= d_chk_err;
      bus.mem_addr  <= bus.d_addr;
      if (bus.d_we)
        bus.mem_wdata <= bus.d_wdata;
    end else begin
      iss_valid     <= 1'b0;
    end
  end

  assign bus.mem_rw = iss_valid && !iss_err && ((iss_port == PORT_FETCH) || !iss_we);
  assign bus.mem_wr = iss_valid && !iss_err && (iss_port == PORT_DATA) && iss_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.if_rvalid <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.d_err     <= 1'b0;
    end else begin
      bus.if_rvalid <= iss_valid && (iss_port == PORT_FETCH);
      bus.if_err    <= iss_valid && (iss_port == PORT_FETCH) && iss_err;
      bus.d_rvalid  <= iss_valid && (iss_port == PORT_DATA);
      bus.d_err     <= iss_valid && (iss_port == PORT_DATA) && iss_err;
    end
  end

  // Read data comes straight from the memory buses, masked during reset.
  assign bus.if_rdata = rst ? '0 : bus.mem_iout;
  assign bus.d_rdata  = rst ? '0 : bus.mem_out;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter with a small synchronous
// memory model; error expectations follow MEM_ARB_ERR_CHECK_EN.
module tb_mem_access_arbiter;

`ifdef MEM_ARB_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem_model [logic [31:0]];

  mem_access_arbiter_if bus ();

  mem_access_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return mem_model.exists(k) ? mem_model[k] : 32'h0;
  endfunction

  // Unified memory: writes land and reads sample at the edge ending the strobe.
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_out  <= '0;
      bus.mem_iout <= '0;
    end else begin
      if (bus.mem_wr)
        mem_model[{bus.mem_addr[31:2], 2'b00}] = bus.mem_wdata;
      if (bus.mem_rw) begin
        bus.mem_out  <= mem_read(bus.mem_addr);
        bus.mem_iout <= mem_read(bus.mem_pca);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic f_req, input logic [31:0] f_addr,
                               input logic dr, input logic we,
                               input logic [31:0] da, input logic [31:0] dw);
    bus.if_req  = f_req;
    bus.if_addr = f_addr;
    bus.d_req   = dr;
    bus.d_we    = we;
    bus.d_addr  = da;
    bus.d_wdata = dw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem_model[32'h0010_0000] = 32'h1171_9195;
    mem_model[32'h0100_0000] = 32'h0000_0013;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #2;
    checkOutput("rst_if_rdy",    32'(bus.if_rdy),    32'd0);
    checkOutput("rst_d_rdy",     32'(bus.d_rdy),     32'd0);
    checkOutput("rst_mem_rw",    32'(bus.mem_rw),    32'd0);
    checkOutput("rst_mem_wr",    32'(bus.mem_wr),    32'd0);
    checkOutput("rst_mem_pca",   bus.mem_pca,        32'd0);
    checkOutput("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    checkOutput("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_if_rdy", 32'(bus.if_rdy), 32'd1);
    checkOutput("idle_d_rdy",  32'(bus.d_rdy),  32'd1);

    $display("[TB] fetch only");
    applyStimulus(1'b1, 32'h0100_0000, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("f_if_rdy", 32'(bus.if_rdy), 32'd1);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("f_mem_rw",    32'(bus.mem_rw),    32'd1);
    checkOutput("f_mem_wr",    32'(bus.mem_wr),    32'd0);
    checkOutput("f_mem_pca",   bus.mem_pca,        32'h0100_0000);
    checkOutput("f_early_rv",  32'(bus.if_rvalid), 32'd0);
    step();
    checkOutput("f_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    checkOutput("f_if_err",    32'(bus.if_err),    32'd0);
    checkOutput("f_if_rdata",  bus.if_rdata,       32'h0000_0013);
    checkOutput("f_rw_off",    32'(bus.mem_rw),    32'd0);
    step();
    checkOutput("f_rv_pulse",  32'(bus.if_rvalid), 32'd0);

    $display("[TB] store then load");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
    checkOutput("st_mem_wr",    32'(bus.mem_wr), 32'd1);
    checkOutput("st_mem_rw",    32'(bus.mem_rw), 32'd0);
    checkOutput("st_mem_addr",  bus.mem_addr,    32'h8000_0010);
    checkOutput("st_mem_wdata", bus.mem_wdata,   32'hDEAD_BEEF);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("st_ack",       32'(bus.d_rvalid), 32'd1);
    checkOutput("st_err",       32'(bus.d_err),    32'd0);
    checkOutput("ld_mem_rw",    32'(bus.mem_rw),   32'd1);
    step();
    checkOutput("ld_rvalid",    32'(bus.d_rvalid), 32'd1);
    checkOutput("ld_rdata",     bus.d_rdata,       32'hDEAD_BEEF);
    step();
    checkOutput("ld_rv_pulse",  32'(bus.d_rvalid), 32'd0);

    $display("[TB] constant load");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0010_0000, '0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("cl_mem_addr", bus.mem_addr,      32'h0010_0000);
    step();
    checkOutput("cl_rvalid",   32'(bus.d_rvalid), 32'd1);
    checkOutput("cl_rdata",    bus.d_rdata,       32'h1171_9195);
    step();

    $display("[TB] contention");
    applyStimulus(1'b1, 32'h0100_0000, 1'b1, 1'b0, 32'h0010_0000, '0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput($sformatf("ct_d_rdy_%0d", i),  32'(bus.d_rdy),  32'((i % 5) != 4));
      checkOutput($sformatf("ct_if_rdy_%0d", i), 32'(bus.if_rdy), 32'((i % 5) == 4));
      step();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step();
    step();

    $display("[TB] error accesses");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0010_0004, 32'h1234_5678);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("es_mem_wr", 32'(bus.mem_wr),   32'(!ERR_EN));
    checkOutput("es_mem_rw", 32'(bus.mem_rw),   32'd0);
    step();
    checkOutput("es_rvalid", 32'(bus.d_rvalid), 32'd1);
    checkOutput("es_err",    32'(bus.d_err),    32'(ERR_EN));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h8000_0002, '0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("el_mem_rw", 32'(bus.mem_rw),   32'(!ERR_EN));
    step();
    checkOutput("el_rvalid", 32'(bus.d_rvalid), 32'd1);
    checkOutput("el_err",    32'(bus.d_err),    32'(ERR_EN));
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, '0, '0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("ef_mem_rw", 32'(bus.mem_rw),    32'(!ERR_EN));
    step();
    checkOutput("ef_rvalid", 32'(bus.if_rvalid), 32'd1);
    checkOutput("ef_err",    32'(bus.if_err),    32'(ERR_EN));
    step();

    $display("[TB] reset during load");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h8000_0010, '0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("rl_mem_rw", 32'(bus.mem_rw), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rr_mem_rw",    32'(bus.mem_rw),    32'd0);
    checkOutput("rr_mem_wr",    32'(bus.mem_wr),    32'd0);
    checkOutput("rr_mem_addr",  bus.mem_addr,       32'd0);
    checkOutput("rr_mem_pca",   bus.mem_pca,        32'd0);
    checkOutput("rr_mem_wdata", bus.mem_wdata,      32'd0);
    checkOutput("rr_if_rdy",    32'(bus.if_rdy),    32'd0);
    checkOutput("rr_d_rdy",     32'(bus.d_rdy),     32'd0);
    checkOutput("rr_d_rdata",   bus.d_rdata,        32'd0);
    checkOutput("rr_if_rdata",  bus.if_rdata,       32'd0);
    step();
    checkOutput("rr_d_rvalid",  32'(bus.d_rvalid),  32'd0);
    checkOutput("rr_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    checkOutput("rr_d_err",     32'(bus.d_err),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    checkOutput("rr_no_rvalid", 32'(bus.d_rvalid),  32'd0);
    checkOutput("rr_no_strobe", 32'(bus.mem_rw),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

- Sits between the fetch unit, the load/store unit and the unified `Memory` block.
- Serialises all traffic onto one memory access per cycle, with valid/ready request handshakes and fixed-latency responses.
- Decodes the address map: instruction region `0x010xxxxx`, constant region `0x001xxxxx`, data region `0x800xxxxx`.
- Gives data priority over fetch, with a starvation guard.

## Interface
- `STARVE_LIMIT`, 4: maximum consecutive data grants while fetch is pending (range 1–15).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request valid.
- `if_addr` in 32: fetch byte address.
- `if_rdy` out 1: fetch request accepted this edge when `if_req` && `if_rdy`.
- `if_rvalid` out 1: fetch response pulse.
- `if_rdata` out 32: instruction word; valid while `if_rvalid`.
- `if_err` out 1: fetch error, qualified by `if_rvalid`.
- `d_req` in 1: data request valid.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_rdy` out 1: data request accepted when `d_req` && `d_rdy`.
- `d_rvalid` out 1: load/store response pulse; a store response is an acknowledge.
- `d_rdata` out 32: load data.
- `d_err` out 1: data error, qualified by `d_rvalid`.
- `mem_rw` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `mem_addr` out 32: memory data address.
- `mem_pca` out 32: memory instruction address.
- `mem_wdata` out 32: memory write data.
- `mem_out` in 32: memory data read bus.
- `mem_iout` in 32: memory instruction read bus.

## Operation
**Arbitration (combinational)**
- At most one request is accepted per cycle.
- `d_rdy` = !starve.
- `if_rdy` = starve || !`d_req`.
- starve = (`starve_cnt` == `STARVE_LIMIT`) && `if_req`.

**Starvation counter `starve_cnt`** (4 bits)
- Increments on a data accept while `if_req` is high.
- Clears on a fetch accept, or on any cycle with `if_req` low.
- Saturates at `STARVE_LIMIT`.

**Issue stage**
- Registered state: `iss_valid`, `iss_port` (FETCH/DATA), `iss_we`, `iss_err`, address, wdata.
- On accept, the stage loads the request.
- Otherwise `iss_valid` clears.

**Memory drive** (from the issue stage)
- Fetch: `mem_rw`=1, `mem_pca`=addr.
- Load: `mem_rw`=1, `mem_addr`=addr.
- Store: `mem_wr`=1, `mem_addr`=addr, `mem_wdata`=wdata.
- Error entries drive no strobe.
- Idle: all strobes 0; address and data outputs hold their last value.

**Response stage** (registered one cycle after issue)
- Asserts `if_rvalid` or `d_rvalid` for exactly one cycle, with `*_err` = `iss_err`.
- `if_rdata` = `mem_iout` and `d_rdata` = `mem_out`, passed through combinationally.
- Read data is meaningful only while the corresponding `rvalid` is high and `err` is 0.

**Legal accesses** (anything else is an error)
- Fetch: region `0x010` and `addr[1:0]`==0.
- Load: region `0x001` or `0x800`, and word-aligned.
- Store: region `0x800`, and word-aligned.

**Reset**
- All outputs 0; `starve_cnt`, `iss_valid` and the response stage are cleared.
- Any request in flight is dropped: no `rvalid`, no strobe after reset asserts.

## Timing
- Accept at edge E0; strobe high during E0→E1; the memory samples at E1.
- `*_rvalid` high during E1→E2.
- Load/fetch latency is 2 edges from accept; throughput is 1 access per cycle.
- Back-to-back data accesses pipeline.
- Store at E0 followed by a load of the same address at E1: the load returns the new data (the write lands at E1, the read samples at E2).
- Simultaneous `if_req` and `d_req`: data wins unless starve is set, in which case fetch wins and the counter clears.
- `STARVE_LIMIT` data grants are followed by exactly one fetch grant.
- Requesters hold `req` and payload stable until accepted.
- Responses cannot be back-pressured.

## Configuration
- `MEM_ARB_ERR_CHECK_EN` defined: region and alignment checks active, as described under Operation.
- `MEM_ARB_ERR_CHECK_EN` undefined:
  - `iss_err` is tied 0.
  - Every accepted request drives its strobe.
  - `if_err` and `d_err` are constant 0.
  - Arbitration and timing are unchanged.

## Structure
- Package `mem_map_pkg` holds:
  - Region constants `REGION_IMEM`=12'h010, `REGION_CONST`=12'h001, `REGION_DMEM`=12'h800.
  - Port enum `port_e` {PORT_FETCH, PORT_DATA}.
  - Function `addr_legal(addr, is_fetch, is_store)`.
- One sub-module `mem_addr_check` (combinational legality decode) is instantiated once per port.

## Test plan
- Fetch only: `if_addr`=0x0100_0000 accepted at E0 → `mem_rw`=1, `mem_pca`=0x0100_0000 in E0→E1; `if_rvalid`=1, `if_err`=0 in E1→E2.
- Store then load: store 0xDEAD_BEEF to 0x8000_0010, load the same address next cycle → `d_rvalid` pulses for both; load `d_rdata`=0xDEAD_BEEF.
- Constant load from 0x0010_0000 → `d_rdata`=0x1171_9195.
- Contention: `if_req` and `d_req` held high continuously with `STARVE_LIMIT`=4 → grant pattern D,D,D,D,F repeating.
- Errors: store to 0x0010_0004, load from 0x8000_0002, fetch from 0x8000_0000 → no strobes; each `*_err`=1 with its `rvalid`. With the macro undefined, strobes issue and `err`=0.
- `rst` asserted in the cycle after a load accept → no `d_rvalid`; all outputs 0 while `rst` is high.
